// File: rtl/nv_fifo_rws_64x32_pkg.sv
// Shared sizing constants and pointer helper for the 64x32 valid/ready FIFO.
package nv_fifo_rws_64x32_pkg;

  localparam int unsigned FIFO_DEPTH = 64;
  localparam int unsigned FIFO_AW    = 6;
  localparam int unsigned FIFO_CW    = 7;
  localparam int unsigned FIFO_DW    = 32;

  typedef logic [FIFO_AW-1:0] fifo_ptr_t;

  // Wraps 63 -> 0 through natural 6-bit overflow.
  function automatic fifo_ptr_t ptr_inc(input fifo_ptr_t ptr);
    return ptr + fifo_ptr_t'(1);
  endfunction

endpackage

// File: rtl/nv_ram_rws_64x32.sv
// 64x32 two-port RAM: synchronous write, registered read address, combinational read data.
module nv_ram_rws_64x32
  import nv_fifo_rws_64x32_pkg::*;
(
  input  logic               clk,
  input  logic [FIFO_AW-1:0] ra,
  input  logic               re,
  output logic [FIFO_DW-1:0] dout,
  input  logic [FIFO_AW-1:0] wa,
  input  logic               we,
  input  logic [FIFO_DW-1:0] di,
  input  logic [31:0]        pwrbus_ram_pd
);

  logic [FIFO_DW-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] ra_q;

  // Power-control bus has no behavioural effect in this model.
  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wa] <= di;
    end
  end

  // Read address is not reset; the owner realigns it by pulsing re.
  always_ff @(posedge clk) begin
    if (re) begin
      ra_q <= ra;
    end
  end

  assign dout = mem_q[ra_q];

endmodule

// File: rtl/nv_fifo_rws_64x32.sv
// 64-entry x 32-bit valid/ready FIFO; head is the RAM output at the read pointer, no output flop.
module nv_fifo_rws_64x32
  import nv_fifo_rws_64x32_pkg::*;
#(
  parameter int unsigned AFULL_LVL = 56
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_pvld,
  output logic               wr_prdy,
  input  logic [FIFO_DW-1:0] wr_pd,
  output logic               rd_pvld,
  input  logic               rd_prdy,
  output logic [FIFO_DW-1:0] rd_pd,
  input  logic               flush,
  output logic [FIFO_CW-1:0] wr_count,
  output logic               afull,
  input  logic [31:0]        pwrbus_ram_pd
);

  localparam logic [FIFO_CW-1:0] CountFull = FIFO_CW'(FIFO_DEPTH);
  localparam logic [FIFO_CW-1:0] AfullLvl  = FIFO_CW'(AFULL_LVL);

  fifo_ptr_t          wr_ptr_q, wr_ptr_d;
  fifo_ptr_t          rd_ptr_q, rd_ptr_d;
  logic [FIFO_CW-1:0] count_q, count_d;
  logic               afull_q, afull_d;

  logic               push, pop, clear;
  fifo_ptr_t          ram_ra, ram_wa;
  logic               ram_re, ram_we;
  logic [FIFO_DW-1:0] ram_di;

  // Full blocks writes even alongside a pop: the write would hit the address being read.
  assign wr_prdy = (count_q != CountFull) && !flush;
  assign rd_pvld = (count_q != '0);
  assign push    = wr_pvld && wr_prdy && !rst;
  assign pop     = rd_pvld && rd_prdy;
  assign clear   = rst || flush;

  always_comb begin
    ram_we = push;
    ram_wa = wr_ptr_q;
    ram_di = wr_pd;
    // Keep the RAM's registered address equal to rd_ptr at all times.
    ram_re = clear || pop;
    ram_ra = clear ? '0 : ptr_inc(rd_ptr_q);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + FIFO_CW'(push) - FIFO_CW'(pop);
    end
    afull_d = (count_d >= AfullLvl);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      afull_q  <= afull_d;
    end
  end

  assign wr_count = count_q;
  assign afull    = afull_q;

  nv_ram_rws_64x32 u_ram (
    .clk           (clk),
    .ra            (ram_ra),
    .re            (ram_re),
    .dout          (rd_pd),
    .wa            (ram_wa),
    .we            (ram_we),
    .di            (ram_di),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

endmodule

// File: tb/tb_nv_fifo_rws_64x32.sv
// Randomised bench for nv_fifo_rws_64x32 against a queue-based reference model.
module tb_nv_fifo_rws_64x32;

  localparam int unsigned Depth = 64;
  localparam int unsigned Afull = 56;

  logic        clk;
  logic        rst;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [31:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [31:0] rd_pd;
  logic        flush;
  logic [6:0]  wr_count;
  logic        afull;
  logic [31:0] pwrbus_ram_pd;

  nv_fifo_rws_64x32 #(.AFULL_LVL(Afull)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_pvld       (wr_pvld),
    .wr_prdy       (wr_prdy),
    .wr_pd         (wr_pd),
    .rd_pvld       (rd_pvld),
    .rd_prdy       (rd_prdy),
    .rd_pd         (rd_pd),
    .flush         (flush),
    .wr_count      (wr_count),
    .afull         (afull),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [31:0] model_q [$];
  bit          model_afull = 1'b0;
  bit          hold        = 1'b0;
  logic [31:0] hold_pd;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one cycle, compare outputs mid-cycle, then advance the model past the edge.
  task automatic cycle(input logic wv, input logic [31:0] wd, input logic rp,
                       input logic fl, input logic rs);
    bit e_prdy, e_pvld, do_push, do_pop;
    wr_pvld = wv;
    wr_pd   = wd;
    rd_prdy = rp;
    flush   = fl;
    rst     = rs;
    #3;
    e_prdy = (model_q.size() != Depth) && !fl;
    e_pvld = (model_q.size() != 0);
    check("wr_prdy",  32'(wr_prdy),  32'(e_prdy));
    check("rd_pvld",  32'(rd_pvld),  32'(e_pvld));
    check("wr_count", 32'(wr_count), 32'(model_q.size()));
    check("afull",    32'(afull),    32'(model_afull));
    if (e_pvld) check("rd_pd", rd_pd, model_q[0]);
    if (hold)   check("rd_pd_stable", rd_pd, hold_pd);
    hold    = e_pvld && !rp && !fl && !rs;
    hold_pd = rd_pd;
    do_push = wv && e_prdy && !rs;
    do_pop  = e_pvld && rp;
    @(posedge clk);
    #1;
    if (rs || fl) begin
      model_q.delete();
      model_afull = 1'b0;
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(wd);
      model_afull = (model_q.size() >= Afull);
    end
  endtask

  initial begin
    wr_pvld       = 1'b0;
    wr_pd         = '0;
    rd_prdy       = 1'b0;
    flush         = 1'b0;
    rst           = 1'b1;
    pwrbus_ram_pd = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Fill to full, then one rejected extra write.
    for (int i = 1; i <= 64; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h41, 1'b0, 1'b0, 1'b0);
    check("full_count", 32'(wr_count), 32'd64);
    check("full_afull", 32'(afull), 32'd1);

    // Drain in order.
    for (int i = 0; i < 64; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("empty_pvld", 32'(rd_pvld), 32'd0);

    // Sustained stream; pointers wrap several times.
    for (int i = 0; i < 200; i++) cycle(1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Push/pop together at count 1.
    cycle(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h5A5A_5A5A, 1'b1, 1'b0, 1'b0);
    check("pp_rd_pd", rd_pd, 32'h5A5A_5A5A);
    check("pp_count", 32'(wr_count), 32'd1);

    // Random traffic with backpressure.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 199) == 0), 1'b0);
    end

    // Flush at count 37 with a concurrent write, then with reset instead.
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 37; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      check("pre_clear_count", 32'(wr_count), 32'd37);
      cycle(1'b1, 32'hDEAD_BEEF, 1'($urandom_range(0, 1)), (k == 0), (k == 1));
      check("clear_count", 32'(wr_count), 32'd0);
      check("clear_pvld", 32'(rd_pvld), 32'd0);
      cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
      check("post_clear_pd", rd_pd, 32'h1234_5678);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
